hilo_unit: RTL and testbench
============================

# hilo_unit

Architectural HI/LO register pair for the EXE stage, directly downstream of the multiplier. It captures 64-bit mult/madd/msub results when the multiplier signals completion and serves MTHI/MTLO writes and MFHI/MFLO reads. It feeds the current `{HI,LO}` back to the multiplier as the accumulate operand. A pending-operation scoreboard stalls reads and writes that would race an in-flight multiply.

## Interface
- No parameters; word width fixed at 32 bits.
- `clk  in  1  ` single clock; all state updates on the rising edge.
- `rst  in  1  ` reset; asynchronous, active-low (low = reset).
- `cancel  in  1  ` pipeline flush; kills any in-flight multiply.
- `mulIssue  in  1  ` multiplier accepted an operation this cycle (its request AND operand-ok).
- `mulData_ok  in  1  ` multiplier result valid this cycle.
- `mulRes  in  64  ` multiplier result; bits 63:32 go to HI, bits 31:0 go to LO.
- `mulIssueReady  out  1  ` a new multiply may be issued.
- `HiLoData  out  64  ` `{HI,LO}` accumulate operand to the multiplier.
- `mtReq  in  1  ` MTHI/MTLO request.
- `mtSel  in  1  ` target select: 1 = HI, 0 = LO.
- `mtData  in  32  ` value to write.
- `mtReady  out  1  ` MT write accepted this cycle.
- `mfReq  in  1  ` MFHI/MFLO request.
- `mfSel  in  1  ` source select: 1 = HI, 0 = LO.
- `mfData  out  32  ` read data.
- `mfReady  out  1  ` mfData valid; the read completes this cycle.
- `hiloBusy  out  1  ` at least one multiply is pending.
- `hiloErr  out  1  ` sticky protocol-violation flag.

## Operation
**Registers:** HI[31:0], LO[31:0], pending[1:0] (count of issued, uncompleted multiplies), errFlag.

**Pending counter:**
- mulIssue alone: +1.
- Accepted completion (mulData_ok alone): −1.
- Both in the same cycle: unchanged.
- cancel: pending ← 0, overriding everything else.
- The counter saturates at 3 and at 0. It never wraps.

**Error flag:** errFlag sets on any of:
- mulData_ok while pending==0 and no same-cycle mulIssue;
- mulIssue while pending==3.

errFlag clears only on reset.

**Status outputs:**
- hiloBusy = (pending != 0).
- mulIssueReady = !cancel && (pending==0 || (pending==1 && mulData_ok)). This enforces one multiply in flight.

**Result write:**
- On mulData_ok && !cancel: HI ← mulRes[63:32] and LO ← mulRes[31:0].
- When cancel coincides with mulData_ok, the result is dropped and HI/LO are unchanged.

**MT write:**
- mtReady = mtReq && !hiloBusy && !mulData_ok && !cancel.
- When mtReady is high, the selected register ← mtData.
- An MT write never coexists with a multiply result write. The multiply result always wins.

**HiLoData:** always the registered `{HI,LO}`. HI/LO cannot change during an accumulate's operand window because MT is blocked while busy.

**MF read:**
- mfReady = mfReq && !hiloBusy when HILO_BYPASS_EN is undefined; see Configuration for the defined case.
- mfData = selected register.
- mfData is 32'h0 when mfReq is low.

## Timing
- Reset values of outputs:
  - HiLoData = 64'h0, mfData = 0, mfReady = 0, mtReady = 0, hiloBusy = 0, hiloErr = 0.
  - mulIssueReady = 1 (when cancel is low).
- Reset values of registers: HI = LO = 0, pending = 0.
- Reset asserted mid-operation clears all state immediately, with no clock required.
- Write latency: a mulData_ok in cycle N makes HiLoData and mfData reflect the new value in cycle N+1.
- MT write latency: an MT write accepted in cycle N is visible in cycle N+1.
- A same-cycle MF read of a register being MT-written returns the old value.
- All outputs are combinational from registers plus current inputs. There are no internal pipeline stages.

## Configuration
Macro: `HILO_BYPASS_EN`.
- **Defined:** when mulData_ok && !cancel in the cycle of an MF read, the read completes that cycle.
  - mfReady = mfReq && (!hiloBusy || (pending==1 && mulData_ok && !mulIssue)).
  - mfData = mulRes[63:32] or mulRes[31:0] per mfSel.
  - This saves one stall cycle per MFHI/MFLO that follows a multiply.
- **Undefined:** MF waits until pending==0 and reads the registers the cycle after completion.

## Test plan
1. **Reset and MT/MF:**
   - Stimulus: release reset; mtReq=1, mtSel=1, mtData=32'hDEADBEEF; next cycle mfReq=1, mfSel=1.
   - Required: mtReady=1; mfReady=1, mfData=32'hDEADBEEF; HiLoData=64'hDEADBEEF_00000000.
2. **Multiply write and stall:**
   - Stimulus: mulIssue in cycle 0; mulData_ok in cycle 3 with mulRes=64'h00000001_FFFFFFFE; mfReq (LO) from cycle 1.
   - Required: hiloBusy=1 in cycles 1–3. mfReady=0 in cycles 1–3 and 1 in cycle 4, with mfData=32'hFFFFFFFE (bypass off).
   - Required with the macro defined: mfReady=1 in cycle 3 with mfData=32'hFFFFFFFE.
3. **MT blocked while busy:**
   - Stimulus: issue a multiply; mtReq=1 while pending==1.
   - Required: mtReady=0 until the cycle after mulData_ok; LO holds the multiply result before the MT value lands.
4. **Cancel:**
   - Stimulus: mulIssue; cancel and mulData_ok asserted together in cycle 3 with mulRes=64'h1234.
   - Required: HI/LO unchanged; pending=0 next cycle; mulIssueReady=1.
5. **Back-to-back issue:**
   - Stimulus: mulData_ok and mulIssue in the same cycle.
   - Required: pending stays 1; mulIssueReady was 1 in that cycle.
   - Stimulus: mulIssue while pending==1 with no completion.
   - Required: mulIssueReady=0.
6. **Protocol error:**
   - Stimulus: mulData_ok with pending==0.
   - Required: hiloErr=1 from the next cycle, held until reset.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with multiply-pending scoreboard.
// Optional feature: define HILO_BYPASS_EN to let MFHI/MFLO take a completing result directly.
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        cancel,
  input  logic        mulIssue,
  input  logic        mulData_ok,
  input  logic [63:0] mulRes,
  output logic        mulIssueReady,
  output logic [63:0] HiLoData,
  input  logic        mtReq,
  input  logic        mtSel,
  input  logic [31:0] mtData,
  output logic        mtReady,
  input  logic        mfReq,
  input  logic        mfSel,
  output logic [31:0] mfData,
  output logic        mfReady,
  output logic        hiloBusy,
  output logic        hiloErr
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [1:0]  r_pending;
  logic        r_err;

  logic        w_busy;
  logic        w_pend_zero;
  logic        w_pend_one;
  logic        w_pend_full;
  logic        w_err_set;
  logic        w_res_wr;
  logic        w_mt_wr;
  logic [1:0]  w_pending_nxt;
  logic [31:0] w_mf_src;

  assign w_pend_zero = (r_pending == 2'd0);
  assign w_pend_one  = (r_pending == 2'd1);
  assign w_pend_full = (r_pending == 2'd3);
  assign w_busy      = !w_pend_zero;
  assign w_res_wr    = mulData_ok && !cancel;
  assign w_mt_wr     = mtReq && !w_busy && !mulData_ok && !cancel;
  assign w_err_set   = (mulData_ok && w_pend_zero && !mulIssue) || (mulIssue && w_pend_full);

  // Counter saturates at both ends; a simultaneous issue and completion nets out.
  always_comb begin
    w_pending_nxt = r_pending;
    if (cancel) begin
      w_pending_nxt = 2'd0;
    end else if (mulIssue && !mulData_ok && !w_pend_full) begin
      w_pending_nxt = r_pending + 2'd1;
    end else if (!mulIssue && mulData_ok && !w_pend_zero) begin
      w_pending_nxt = r_pending - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= 32'h0;
      r_lo      <= 32'h0;
      r_pending <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      // A multiply result always takes priority; MT is already blocked whenever one lands.
      if (w_res_wr) begin
        r_hi <= mulRes[63:32];
        r_lo <= mulRes[31:0];
      end else if (w_mt_wr) begin
        if (mtSel) begin
          r_hi <= mtData;
        end else begin
          r_lo <= mtData;
        end
      end
    end
  end

  always_comb begin
    w_mf_src = mfSel ? r_hi : r_lo;
`ifdef HILO_BYPASS_EN
    if (w_res_wr) begin
      w_mf_src = mfSel ? mulRes[63:32] : mulRes[31:0];
    end
`endif
  end

`ifdef HILO_BYPASS_EN
  assign mfReady = mfReq && (!w_busy || (w_pend_one && mulData_ok && !mulIssue));
`else
  assign mfReady = mfReq && !w_busy;
`endif

  assign mfData        = mfReq ? w_mf_src : 32'h0;
  assign mtReady       = w_mt_wr;
  assign HiLoData      = {r_hi, r_lo};
  assign hiloBusy      = w_busy;
  assign hiloErr       = r_err;
  assign mulIssueReady = !cancel && (w_pend_zero || (w_pend_one && mulData_ok));

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table plus randomized run against a reference model.
module tb_hilo_unit;

`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cancel, mulIssue, mulData_ok;
  logic [63:0] mulRes;
  logic        mulIssueReady;
  logic [63:0] HiLoData;
  logic        mtReq, mtSel;
  logic [31:0] mtData;
  logic        mtReady;
  logic        mfReq, mfSel;
  logic [31:0] mfData;
  logic        mfReady, hiloBusy, hiloErr;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk(clk), .rst(rst), .cancel(cancel), .mulIssue(mulIssue), .mulData_ok(mulData_ok),
    .mulRes(mulRes), .mulIssueReady(mulIssueReady), .HiLoData(HiLoData),
    .mtReq(mtReq), .mtSel(mtSel), .mtData(mtData), .mtReady(mtReady),
    .mfReq(mfReq), .mfSel(mfSel), .mfData(mfData), .mfReady(mfReady),
    .hiloBusy(hiloBusy), .hiloErr(hiloErr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        can, iss, ok;
    logic [63:0] res;
    logic        mtq, mts;
    logic [31:0] mtd;
    logic        mfq, mfs;
    logic        e_ir, e_busy, e_mt, e_mf;
    logic [31:0] e_mfd;
    logic [63:0] e_hilo;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic can, iss, ok, input logic [63:0] res,
                              input logic mtq, mts, input logic [31:0] mtd,
                              input logic mfq, mfs,
                              input logic e_ir, e_busy, e_mt, e_mf,
                              input logic [31:0] e_mfd, input logic [63:0] e_hilo,
                              input logic e_err);
    vec_t v;
    v.can = can; v.iss = iss; v.ok = ok; v.res = res;
    v.mtq = mtq; v.mts = mts; v.mtd = mtd; v.mfq = mfq; v.mfs = mfs;
    v.e_ir = e_ir; v.e_busy = e_busy; v.e_mt = e_mt; v.e_mf = e_mf;
    v.e_mfd = e_mfd; v.e_hilo = e_hilo; v.e_err = e_err;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_hi, m_lo;
  int          m_pend;
  bit          m_err;

  task automatic idle();
    cancel = 0; mulIssue = 0; mulData_ok = 0; mulRes = '0;
    mtReq = 0; mtSel = 0; mtData = '0; mfReq = 0; mfSel = 0;
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_check(input string tag);
    bit busy, exp_mt, exp_mf, exp_ir;
    logic [31:0] exp_mfd;
    busy   = (m_pend > 0);
    exp_ir = !cancel && (m_pend == 0 || (m_pend == 1 && mulData_ok));
    exp_mt = mtReq && !busy && !mulData_ok && !cancel;
    if (BYP) exp_mf = mfReq && (!busy || (m_pend == 1 && mulData_ok && !mulIssue));
    else     exp_mf = mfReq && !busy;
    if (!mfReq) exp_mfd = 0;
    else if (BYP && mulData_ok && !cancel) exp_mfd = mfSel ? mulRes[63:32] : mulRes[31:0];
    else exp_mfd = mfSel ? m_hi : m_lo;
    chk({tag, " iready"}, mulIssueReady, exp_ir);
    chk({tag, " busy"}, hiloBusy, busy);
    chk({tag, " mtReady"}, mtReady, exp_mt);
    chk({tag, " mfReady"}, mfReady, exp_mf);
    chk({tag, " mfData"}, mfData, exp_mfd);
    chk({tag, " HiLoData"}, HiLoData, {m_hi, m_lo});
    chk({tag, " err"}, hiloErr, m_err);
  endtask

  task automatic model_step();
    bit mt_ok;
    mt_ok = mtReq && (m_pend == 0) && !mulData_ok && !cancel;
    if ((mulData_ok && m_pend == 0 && !mulIssue) || (mulIssue && m_pend == 3)) m_err = 1;
    if (mulData_ok && !cancel) begin
      m_hi = mulRes[63:32];
      m_lo = mulRes[31:0];
    end else if (mt_ok) begin
      if (mtSel) m_hi = mtData; else m_lo = mtData;
    end
    if (cancel) m_pend = 0;
    else begin
      m_pend = m_pend + int'(mulIssue) - int'(mulData_ok);
      if (m_pend > 3) m_pend = 3;
      if (m_pend < 0) m_pend = 0;
    end
  endtask

  vec_t vq[$];

  initial begin
    logic [63:0] h1, r2, r3, h4, r5, r7, r8;
    h1 = 64'hDEADBEEF_00000000;
    r2 = 64'h00000001_FFFFFFFE;
    r3 = 64'hAAAA5555_12345678;
    h4 = 64'hAAAA5555_0000CAFE;
    r5 = 64'h00000002_00000003;
    r7 = 64'h00000006_00000007;
    r8 = 64'h00000009_00000009;
    //           can iss ok res          mtq mts mtd           mfq mfs  ir bsy mt mf mfd                         hilo  err
    vq.push_back(mk(0, 0, 0, 64'h0,      1, 1, 32'hDEADBEEF, 0, 0,   1, 0, 1, 0, 32'h0,                      64'h0, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 1,   1, 0, 0, 1, 32'hDEADBEEF,               h1, 0));
    vq.push_back(mk(0, 1, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      h1, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 0,   0, 1, 0, 0, 32'h0,                      h1, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 0,   0, 1, 0, 0, 32'h0,                      h1, 0));
    vq.push_back(mk(0, 0, 1, r2,         0, 0, 32'h0,        1, 0,   1, 1, 0, BYP, BYP ? 32'hFFFFFFFE : 32'h0, h1, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 0,   1, 0, 0, 1, 32'hFFFFFFFE,               r2, 0));
    vq.push_back(mk(0, 1, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      r2, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      1, 0, 32'h0000CAFE, 0, 0,   0, 1, 0, 0, 32'h0,                      r2, 0));
    vq.push_back(mk(0, 0, 1, r3,         1, 0, 32'h0000CAFE, 0, 0,   1, 1, 0, 0, 32'h0,                      r2, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      1, 0, 32'h0000CAFE, 1, 0,   1, 0, 1, 1, 32'h12345678,               r3, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 0,   1, 0, 0, 1, 32'h0000CAFE,               h4, 0));
    vq.push_back(mk(0, 1, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(1, 0, 1, 64'h1234,   0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 1, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 1, 1, r5,         0, 0, 32'h0,        0, 0,   1, 1, 0, 0, 32'h0,                      h4, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      r5, 0));
    vq.push_back(mk(0, 1, 0, 64'h0,      0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      r5, 0));
    vq.push_back(mk(0, 0, 1, 64'h5,      0, 0, 32'h0,        0, 0,   0, 1, 0, 0, 32'h0,                      r5, 0));
    vq.push_back(mk(0, 0, 1, r7,         0, 0, 32'h0,        0, 0,   1, 1, 0, 0, 32'h0,                      64'h5, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        1, 1,   1, 0, 0, 1, 32'h00000006,               r7, 0));
    vq.push_back(mk(0, 0, 1, r8,         0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      r7, 0));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      r8, 1));
    vq.push_back(mk(0, 0, 0, 64'h0,      1, 1, 32'h00000001, 0, 0,   1, 0, 1, 0, 32'h0,                      r8, 1));
    vq.push_back(mk(0, 0, 0, 64'h0,      0, 0, 32'h0,        0, 0,   1, 0, 0, 0, 32'h0,                      64'h00000001_00000009, 1));

    // Reset state
    idle();
    rst = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset iready", mulIssueReady, 1);
    chk("reset HiLoData", HiLoData, 64'h0);
    chk("reset busy", hiloBusy, 0);
    chk("reset err", hiloErr, 0);
    chk("reset mtReady", mtReady, 0);
    chk("reset mfReady", mfReady, 0);
    chk("reset mfData", mfData, 0);
    @(negedge clk);
    rst = 1;

    // Directed vector table, one row per cycle
    foreach (vq[i]) begin
      @(negedge clk);
      cancel = vq[i].can; mulIssue = vq[i].iss; mulData_ok = vq[i].ok; mulRes = vq[i].res;
      mtReq = vq[i].mtq; mtSel = vq[i].mts; mtData = vq[i].mtd;
      mfReq = vq[i].mfq; mfSel = vq[i].mfs;
      #2;
      chk($sformatf("row%0d iready", i), mulIssueReady, vq[i].e_ir);
      chk($sformatf("row%0d busy", i), hiloBusy, vq[i].e_busy);
      chk($sformatf("row%0d mtReady", i), mtReady, vq[i].e_mt);
      chk($sformatf("row%0d mfReady", i), mfReady, vq[i].e_mf);
      chk($sformatf("row%0d mfData", i), mfData, vq[i].e_mfd);
      chk($sformatf("row%0d HiLoData", i), HiLoData, vq[i].e_hilo);
      chk($sformatf("row%0d err", i), hiloErr, vq[i].e_err);
    end

    // Asynchronous reset clears the sticky error without a clock edge
    @(negedge clk);
    idle();
    #2 rst = 0;
    #1;
    chk("async reset err", hiloErr, 0);
    chk("async reset HiLoData", HiLoData, 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1;

    // Randomized run against the reference model, with one mid-run reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c == 700) begin
        idle();
        mulIssue = 1;
        #2;
        model_check("pre-reset");
        model_step();
        @(negedge clk);
        idle();
        #1 rst = 0;
        #1;
        chk("midop reset busy", hiloBusy, 0);
        chk("midop reset HiLoData", HiLoData, 64'h0);
        chk("midop reset err", hiloErr, 0);
        model_reset();
        @(negedge clk);
        rst = 1;
      end
      cancel     = ($urandom_range(0, 15) == 0);
      mulIssue   = ($urandom_range(0, 3) == 0);
      mulData_ok = ($urandom_range(0, 3) == 0);
      mulRes     = {$urandom, $urandom};
      mtReq      = $urandom_range(0, 1);
      mtSel      = $urandom_range(0, 1);
      mtData     = $urandom;
      mfReq      = $urandom_range(0, 1);
      mfSel      = $urandom_range(0, 1);
      #2;
      model_check($sformatf("rand%0d", c));
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
